hazard_stall_controller: RTL and testbench

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

---
 rtl/hazard_stall_controller.sv | 116 +++++++++++
 tb/tb_hazard_stall_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard unit: operand forwarding selects, load-use interlock,
// multi-cycle ALU stall sequencing and branch flush gating.
module hazard_stall_controller #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        exe_wreg,
    input  logic        exe_m2reg,
    input  logic [4:0]  exe_rn,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic [4:0]  mem_rn,
    input  logic        id_mul_start,
    input  logic        id_branch_taken,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        wpcir,
    output logic        id_bubble,
    output logic        if_flush,
    output logic        mul_busy,
    output logic        mul_done,
    output logic [15:0] stall_count
);

    typedef enum logic {RUN, BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_stall_count;
    logic        w_load_stall;

    // EXE result beats MEM; register 0 is hardwired and never forwarded
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (exe_wreg && !exe_m2reg && exe_rn != 5'd0 && exe_rn == src)
            sel = 2'b01;
        else if (mem_wreg && !mem_m2reg && mem_rn != 5'd0 && mem_rn == src)
            sel = 2'b10;
        else if (mem_wreg && mem_m2reg && mem_rn != 5'd0 && mem_rn == src)
            sel = 2'b11;
        return sel;
    endfunction

    always_comb begin
        fwda = fwd_sel(id_rs);
        fwdb = fwd_sel(id_rt);
    end

    assign w_load_stall = exe_wreg && exe_m2reg && (exe_rn != 5'd0) &&
                          ((id_use_rs && exe_rn == id_rs) || (id_use_rt && exe_rn == id_rt));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        wpcir       = 1'b1;
        id_bubble   = 1'b0;
        mul_busy    = 1'b0;
        mul_done    = 1'b0;
        case (r_state)
            RUN: begin
                // a load-use hazard defers any multi-cycle start to a later cycle
                if (w_load_stall) begin
                    wpcir     = 1'b0;
                    id_bubble = 1'b1;
                end else if (id_mul_start) begin
                    wpcir       = 1'b0;
                    id_bubble   = 1'b1;
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            BUSY: begin
                mul_busy = 1'b1;
                if (r_cnt != 4'd0) begin
                    wpcir     = 1'b0;
                    id_bubble = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    mul_done    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign if_flush = id_branch_taken & wpcir;

    always_ff @(posedge clk) begin
        if (clr)
            r_stall_count <= 16'd0;
        else if (!wpcir && r_stall_count != 16'hFFFF)
            r_stall_count <= r_stall_count + 16'd1;
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Random and directed stimulus for hazard_stall_controller, checked every
// cycle against a cycle-count reference model.
module tb_hazard_stall_controller;

    localparam int MC = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  id_rs, id_rt, exe_rn, mem_rn;
    logic        id_use_rs, id_use_rt, exe_wreg, exe_m2reg, mem_wreg, mem_m2reg;
    logic        id_mul_start, id_branch_taken;
    logic [1:0]  fwda, fwdb;
    logic        wpcir, id_bubble, if_flush, mul_busy, mul_done;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;
    int m_rem = 0;      // BUSY cycles still to come, including the release cycle
    int m_sc  = 0;
    bit m_ok  = 0;

    hazard_stall_controller #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .clr(clr), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .id_mul_start(id_mul_start), .id_branch_taken(id_branch_taken),
        .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .id_bubble(id_bubble),
        .if_flush(if_flush), .mul_busy(mul_busy), .mul_done(mul_done),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_fwd(input int src);
        if (src == 0) return 0;
        if (exe_wreg && !exe_m2reg && exe_rn == src) return 1;
        if (mem_wreg && mem_rn == src) return mem_m2reg ? 3 : 2;
        return 0;
    endfunction

    function automatic bit m_load();
        return exe_wreg && exe_m2reg && exe_rn != 0 &&
               ((id_use_rs && exe_rn == id_rs) || (id_use_rt && exe_rn == id_rt));
    endfunction

    function automatic bit m_stall();
        if (m_rem == 0) return m_load() || id_mul_start;
        return m_rem != 1;
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            m_rem = 0;
            m_sc  = 0;
            m_ok  = 1;
        end else begin
            if (m_stall() && m_sc < 65535) m_sc++;
            if (m_rem > 0) m_rem--;
            else if (!m_load() && id_mul_start) m_rem = MC;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("fwda", fwda, m_fwd(id_rs));
            chk("fwdb", fwdb, m_fwd(id_rt));
            chk("wpcir", wpcir, !m_stall());
            chk("id_bubble", id_bubble, m_stall());
            chk("if_flush", if_flush, id_branch_taken && !m_stall());
            chk("mul_busy", mul_busy, m_rem > 0);
            chk("mul_done", mul_done, m_rem == 1);
            chk("stall_count", stall_count, m_sc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        exe_wreg = 0; exe_m2reg = 0; exe_rn = 0;
        mem_wreg = 0; mem_m2reg = 0; mem_rn = 0;
        id_mul_start = 0; id_branch_taken = 0;
    endtask

    task automatic do_reset();
        step(); idle(); clr = 1;
        step(); clr = 0;
    endtask

    initial begin
        idle();
        clr = 1;
        do_reset();
        #1;
        chk("rst_busy", mul_busy, 0);
        chk("rst_done", mul_done, 0);
        chk("rst_sc", stall_count, 0);
        chk("rst_wpcir", wpcir, 1);

        // forwarding priority
        exe_wreg = 1; exe_rn = 5; mem_wreg = 1; mem_rn = 5; id_rs = 5;
        #1 chk("fwd_exe", fwda, 1);
        exe_rn = 6;
        #1 chk("fwd_mem", fwda, 2);
        mem_m2reg = 1;
        #1 chk("fwd_load", fwda, 3);

        // load-use on rt
        step(); idle();
        exe_wreg = 1; exe_m2reg = 1; exe_rn = 7; id_rt = 7; id_use_rt = 1;
        #1 chk("ld_wpcir", wpcir, 0);
        chk("ld_bubble", id_bubble, 1);
        step(); idle();
        chk("ld_sc", stall_count, 1);
        exe_wreg = 1; exe_m2reg = 1; exe_rn = 7; id_rt = 7; id_use_rt = 0;
        #1 chk("ld_nouse", wpcir, 1);

        // r0 never hazards
        step(); idle();
        exe_wreg = 1; exe_m2reg = 1; exe_rn = 0; id_rs = 0; id_use_rs = 1;
        #1 chk("r0_fwda", fwda, 0);
        chk("r0_wpcir", wpcir, 1);

        // branch flush gated by stall
        step(); idle();
        exe_wreg = 1; exe_m2reg = 1; exe_rn = 3; id_rs = 3; id_use_rs = 1; id_branch_taken = 1;
        #1 chk("br_stalled", if_flush, 0);
        step(); exe_m2reg = 0;
        #1 chk("br_flush", if_flush, 1);

        // multi-cycle op, start held high
        do_reset();
        id_mul_start = 1;
        for (int i = 0; i < MC; i++) begin
            #1 chk("mul_wpcir", wpcir, 0);
            step();
        end
        #1 chk("mul_rel", wpcir, 1);
        chk("mul_done", mul_done, 1);
        chk("mul_sc", stall_count, MC);
        step(); id_mul_start = 0;
        #1 chk("mul_after", mul_busy, 0);

        // reset abandons a BUSY op
        do_reset();
        id_mul_start = 1;
        step(); id_mul_start = 0;
        step(); clr = 1;
        step(); clr = 0;
        #1 chk("abort_busy", mul_busy, 0);
        chk("abort_done", mul_done, 0);
        chk("abort_sc", stall_count, 0);
        chk("abort_wpcir", wpcir, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step();
            clr = ($urandom_range(0, 49) == 0);
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_use_rs = 1'($urandom);
            id_use_rt = 1'($urandom);
            exe_wreg = 1'($urandom);
            exe_m2reg = 1'($urandom);
            exe_rn = 5'($urandom_range(0, 7));
            mem_wreg = 1'($urandom);
            mem_m2reg = 1'($urandom);
            mem_rn = 5'($urandom_range(0, 7));
            id_mul_start = ($urandom_range(0, 9) == 0);
            id_branch_taken = 1'($urandom);
        end

        // saturate the stall counter with a held load-use hazard
        do_reset();
        exe_wreg = 1; exe_m2reg = 1; exe_rn = 9; id_rs = 9; id_use_rs = 1;
        repeat (65540) step();
        #1 chk("sat_sc", stall_count, 16'hFFFF);
        step();
        #1 chk("sat_hold", stall_count, 16'hFFFF);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
